// File: rtl/timer_bus_arbiter_pkg.sv
// Shared constants for the timer bus arbiter: timer register map, FSM
// state encoding and the one-hot grant encoding seen on gnt.
package timer_bus_arbiter_pkg;

  localparam logic [1:0] TMR_CTRL   = 2'b00;
  localparam logic [1:0] TMR_PRESET = 2'b01;
  localparam logic [1:0] TMR_COUNT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // owner index (0 = M0, 1 = M1) to the one-hot {M1,M0} grant vector
  function automatic logic [1:0] gnt_onehot(input logic owner);
    return owner ? GNT_M1 : GNT_M0;
  endfunction

endpackage

// File: rtl/timer_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the timer register port.
// stb is a request level held until ack; ack is a one-cycle completion pulse.
interface timer_bus_arbiter_if #(parameter int DW = 32);
  import timer_bus_arbiter_pkg::*;

  logic          m0_stb;
  logic          m0_we;
  logic [1:0]    m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;

  logic          m1_stb;
  logic          m1_we;
  logic [1:0]    m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;

  logic [1:0]    t_addr;
  logic          t_we;
  logic [DW-1:0] t_wdata;
  logic [DW-1:0] t_rdata;

  logic [1:0]    gnt;
  state_t        dbg_state;

  // Environment side: both masters plus the timer's read-data return
  modport master (
    output m0_stb, m0_we, m0_addr, m0_wdata,
    output m1_stb, m1_we, m1_addr, m1_wdata,
    output t_rdata,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  t_addr, t_we, t_wdata, gnt, dbg_state
  );

  modport slave (
    input  m0_stb, m0_we, m0_addr, m0_wdata,
    input  m1_stb, m1_we, m1_addr, m1_wdata,
    input  t_rdata,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output t_addr, t_we, t_wdata, gnt, dbg_state
  );

endinterface

// File: rtl/timer_bus_arbiter_rr_arb2.sv
// Two-requester picker: round-robin when RR_EN=1, M0-first otherwise.
// The pointer only moves when a contested request is actually taken.
module timer_bus_arbiter_rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] grant
);

  logic ptr;  // 0: M0 wins the next contest, 1: M1 wins it

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (RR_EN && ptr) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (RR_EN && take && (req == 2'b11)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/timer_bus_arbiter.sv
// Shares the timer register port between two masters; every access is a
// committed IDLE -> XFER -> DONE sequence with registered read data.
module timer_bus_arbiter
  import timer_bus_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  timer_bus_arbiter_if.slave  bus
);

  state_t        state;
  state_t        state_nx;
  logic [1:0]    req;
  logic [1:0]    pick;
  logic          take;
  logic          owner;
  logic          lat_we;
  logic [1:0]    lat_addr;
  logic [DW-1:0] lat_data;
  logic [DW-1:0] m0_rdata_q;
  logic [DW-1:0] m1_rdata_q;

  assign req  = {bus.m1_stb, bus.m0_stb};
  assign take = (state == ST_IDLE) && (req != 2'b00);

  timer_bus_arbiter_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .take  (take),
    .grant (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Once XFER is entered the access always runs to DONE, stb is not re-checked
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (take) state_nx = ST_XFER;
      ST_XFER: state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= 2'b00;
      lat_data   <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      if (take) begin
        owner    <= pick[1];
        lat_we   <= pick[1] ? bus.m1_we    : bus.m0_we;
        lat_addr <= pick[1] ? bus.m1_addr  : bus.m0_addr;
        lat_data <= pick[1] ? bus.m1_wdata : bus.m0_wdata;
      end
      if ((state == ST_XFER) && !lat_we) begin
        if (owner) begin
          m1_rdata_q <= bus.t_rdata;
        end else begin
          m0_rdata_q <= bus.t_rdata;
        end
      end
    end
  end

  // t_we is decoded from state so an async reset drops it immediately
  always_comb begin
    bus.t_addr    = lat_addr;
    bus.t_wdata   = lat_data;
    bus.t_we      = (state == ST_XFER) && lat_we;
    bus.gnt       = (state == ST_IDLE) ? GNT_NONE : gnt_onehot(owner);
    bus.m0_ack    = (state == ST_DONE) && !owner;
    bus.m1_ack    = (state == ST_DONE) && owner;
    bus.m0_rdata  = m0_rdata_q;
    bus.m1_rdata  = m1_rdata_q;
    bus.dbg_state = state;
  end

endmodule

// File: doc/timer_bus_arbiter.md
Name: timer_bus_arbiter

Overview:
- Shares the single register port of the system timer between two bus masters: M0 (CPU data port) and M1 (debug/DMA port).
- Arbitrates requests and sequences each access as a committed 3-cycle transaction.
- Drives the timer's address, write-enable and write-data lines, then returns registered read data and a one-cycle ACK to the winning master.
- Sits between the CPU/bridge side and the timer; the timer's IRQ line does not pass through this block.

Parameters:
- RR_EN, 1, 1 = round-robin between M0/M1; 0 = fixed priority, M0 always wins.
- DW, 32, data width of all data buses.

Ports:
- CLK_I  in  1  system clock, rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- M0_STB_I  in  1  M0 request; held until M0_ACK_O seen.
- M0_WE_I  in  1  M0 write (1) / read (0).
- M0_ADDR_I  in  2  M0 register select [3:2].
- M0_DATA_I  in  DW  M0 write data.
- M0_DATA_O  out  DW  M0 read data (registered).
- M0_ACK_O  out  1  M0 transaction done, 1-cycle pulse.
- M1_STB_I, M1_WE_I, M1_ADDR_I, M1_DATA_I, M1_DATA_O, M1_ACK_O: same as M0, for M1.
- T_ADDR_O  out  2  to timer ADDR_I.
- T_WE_O  out  1  to timer WE_I.
- T_DATA_O  out  DW  to timer DATA_I.
- T_DATA_I  in  DW  from timer DATA_O (combinational in timer).
- GNT_O  out  2  one-hot current owner, {M1,M0}; 00 when idle.

Behaviour:
- Reset (RST_I=0, async): state=IDLE.
  - T_WE_O=0, T_ADDR_O=0, T_DATA_O=0.
  - M0/M1_ACK_O=0, M0/M1_DATA_O=0, GNT_O=00.
  - Round-robin pointer = "M0 next".
- A reset asserted mid-transaction aborts it: no ACK, no write pulse after reset.
- FSM states IDLE -> XFER -> DONE -> IDLE.
- IDLE, cycle N:
  - If any STB is high, select a winner and latch its WE, ADDR and DATA into internal registers.
  - Set GNT_O to the winner; next state XFER. Otherwise stay in IDLE.
- Selection:
  - Only one requester: it wins.
  - Both requesting with RR_EN=1: the master indicated by the pointer wins, and the pointer flips to the other master.
  - Both requesting with RR_EN=0: M0 wins.
  - The pointer updates only on a contested grant.
- XFER, cycle N+1:
  - T_ADDR_O and T_DATA_O drive the latched values.
  - T_WE_O = latched WE, high for exactly this one cycle.
  - On a read, T_DATA_I is captured into the winner's DATA_O at the end of the cycle.
  - Next state DONE.
- DONE, cycle N+2:
  - Winner's ACK_O=1 for exactly one cycle.
  - T_WE_O=0; GNT_O is held; next state IDLE.
- ACK latency from STB = 2 cycles; maximum throughput is 1 transaction per 3 cycles.
- T_WE_O is 0 in every cycle except a write XFER, so the timer counts normally between accesses.
- A transaction is committed once XFER is entered: it completes and ACKs even if the master drops STB early.
- A master must deassert STB (or issue a new request) after seeing ACK. A STB still high in the IDLE cycle after DONE is treated as a new request.
- The loser's STB stays pending and is served in the next IDLE; with RR_EN=1 no master waits more than one transaction.
- ADDR 2'b11 is forwarded unchanged; the timer ignores writes there and reads return its count.
- DATA_O of a master holds its last read value until that master's next read. Writes do not modify DATA_O.
- Non-owner ACK is always 0. ACK_O is never asserted for both masters in the same cycle.

Decomposition:
- Shared package (timer_pkg):
  - Register address constants: TMR_CTRL=2'b00, TMR_PRESET=2'b01, TMR_COUNT=2'b10.
  - FSM state encoding constants ST_IDLE, ST_XFER, ST_DONE.
  - Grant encoding GNT_NONE/GNT_M0/GNT_M1.
- One natural sub-module: rr_arb2, a 2-requester round-robin/fixed-priority picker with pointer register, under the RR_EN parameter. The FSM and datapath mux stay in the top.

Test Plan:
- Reset mid-XFER: assert RST_I=0 during M0 write XFER -> T_WE_O drops immediately; no M0_ACK_O; GNT_O=00; after release, idle with all outputs 0.
- Single write: M0 writes 32'h0000_0009 to ADDR 00 -> exactly one T_WE_O pulse at N+1 with T_ADDR_O=00, T_DATA_O=9; M0_ACK_O at N+2; timer ctrl reads 9.
- Single read: M1 reads ADDR 01 after preset=32'd100 -> M1_DATA_O=100 at N+2 with M1_ACK_O=1; M0_ACK_O stays 0.
- Contention with RR_EN=1: both STB high continuously, 4 transactions -> grant order M0,M1,M0,M1; ACKs at cycles 2,5,8,11.
- Contention with RR_EN=0: both STB high continuously -> M0 wins every time and M1 is starved; M1 is served in the first IDLE where M0_STB_I=0.
- Counting between accesses: ctrl=32'h1 (mode 00), count=5, then M1 reads COUNT 3 cycles later -> value 2; T_WE_O low throughout the read.
